// File: rtl/xc_malu_pkg.sv
// Shared definitions for the MALU multi-precision sequencer.
package xc_malu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MACC_HI = 2'd1,
        MUL     = 2'd2,
        DONE    = 2'd3
    } mpn_state_t;

    localparam logic [5:0] MUL_LAST = 6'd31;

endpackage

// File: rtl/xc_malu_add33.sv
// 32-bit add/subtract with carry-in; bit 32 is carry-out or borrow.
module xc_malu_add33 (
    input  logic [31:0] lhs,
    input  logic [31:0] rhs,
    input  logic        cin,
    input  logic        sub,
    output logic [32:0] sum
);

    always_comb begin
        if (sub) sum = {1'b0, lhs} - {1'b0, rhs} - {32'b0, cin};
        else     sum = {1'b0, lhs} + {1'b0, rhs} + {32'b0, cin};
    end

endmodule

// File: rtl/xc_malu_mpn_seq.sv
// Multi-precision sequencer: madd/msub in one cycle, macc in two,
// mmul by 32 right-shift shift-add steps plus a completion cycle.
module xc_malu_mpn_seq
    import xc_malu_pkg::*;
(
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        flush,
    input  logic        valid,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [31:0] rs3,
    input  logic        uop_madd,
    input  logic        uop_msub,
    input  logic        uop_macc,
    input  logic        uop_mmul,
    output logic        ready,
    output logic [63:0] result,
    output logic        busy,
    output logic [63:0] acc,
    output logic        carry,
    output logic [5:0]  count
);

    mpn_state_t  state, state_n;
    logic [63:0] acc_n;
    logic        carry_n;
    logic [5:0]  count_n;

    logic [31:0] add_lhs, add_rhs;
    logic        add_cin, add_sub;
    logic [32:0] add_sum;

    logic sel_mmul, sel_macc, sel_msub, sel_madd;

    assign sel_mmul = valid & uop_mmul;
    assign sel_macc = valid & uop_macc & ~uop_mmul;
    assign sel_msub = valid & uop_msub & ~uop_macc & ~uop_mmul;
    assign sel_madd = valid & uop_madd & ~uop_msub & ~uop_macc & ~uop_mmul;

    assign busy = (state != IDLE);

    xc_malu_add33 u_add33 (
        .lhs (add_lhs),
        .rhs (add_rhs),
        .cin (add_cin),
        .sub (add_sub),
        .sum (add_sum)
    );

    // One adder serves every path; the state picks its operands.
    always_comb begin
        add_lhs = rs1;
        add_rhs = rs2;
        add_cin = 1'b0;
        add_sub = 1'b0;
        case (state)
            IDLE: begin
                if (sel_macc) begin
                    add_rhs = rs3;
                end else begin
                    add_cin = rs3[0];
                    add_sub = sel_msub;
                end
            end
            MACC_HI: begin
                add_lhs = rs2;
                add_rhs = '0;
                add_cin = carry;
            end
            MUL: begin
                add_lhs = acc[63:32];
                add_rhs = acc[0] ? rs1 : '0;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_n = state;
        acc_n   = acc;
        carry_n = carry;
        count_n = count;
        ready   = 1'b0;
        result  = '0;
        case (state)
            IDLE: begin
                if (sel_mmul) begin
                    state_n = MUL;
                    acc_n   = {rs3, rs2};
                    carry_n = 1'b0;
                    count_n = '0;
                end else if (sel_macc) begin
                    state_n     = MACC_HI;
                    acc_n[31:0] = add_sum[31:0];
                    carry_n     = add_sum[32];
                end else if (sel_msub || sel_madd) begin
                    ready  = 1'b1;
                    result = {31'b0, add_sum};
                end
            end
            MACC_HI: begin
                ready   = 1'b1;
                result  = {add_sum[31:0], acc[31:0]};
                state_n = IDLE;
            end
            MUL: begin
                // 65->64 right shift: the adder carry lands in bit 63.
                acc_n   = {add_sum, acc[31:1]};
                carry_n = add_sum[32];
                count_n = count + 6'd1;
                if (count == MUL_LAST) begin
                    count_n = '0;
                    state_n = DONE;
                end
            end
            DONE: begin
                ready   = 1'b1;
                result  = acc;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (flush) begin
            state_n = IDLE;
            acc_n   = acc;
            carry_n = 1'b0;
            count_n = '0;
            ready   = 1'b0;
            result  = '0;
        end
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state <= IDLE;
            acc   <= '0;
            carry <= 1'b0;
            count <= '0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            carry <= carry_n;
            count <= count_n;
        end
    end

endmodule

// File: tb/tb_xc_malu_mpn_seq.sv
// Self-checking bench for xc_malu_mpn_seq against an arithmetic reference model.
module tb_xc_malu_mpn_seq;

    logic        g_clk = 1'b0;
    logic        g_reset, flush, valid;
    logic [31:0] rs1, rs2, rs3;
    logic        uop_madd, uop_msub, uop_macc, uop_mmul;
    logic        ready, busy, carry;
    logic [63:0] result, acc;
    logic [5:0]  count;

    int checks = 0;
    int errors = 0;

    logic [63:0] m_acc;
    logic        m_carry;
    logic [5:0]  m_count;

    always #5 g_clk = ~g_clk;

    xc_malu_mpn_seq dut (
        .g_clk    (g_clk),
        .g_reset  (g_reset),
        .flush    (flush),
        .valid    (valid),
        .rs1      (rs1),
        .rs2      (rs2),
        .rs3      (rs3),
        .uop_madd (uop_madd),
        .uop_msub (uop_msub),
        .uop_macc (uop_macc),
        .uop_mmul (uop_mmul),
        .ready    (ready),
        .result   (result),
        .busy     (busy),
        .acc      (acc),
        .carry    (carry),
        .count    (count)
    );

    // sel = {mmul, macc, msub, madd}
    function automatic logic [3:0] pick(input logic [3:0] sel);
        if (sel[3]) return 4'b1000;
        if (sel[2]) return 4'b0100;
        if (sel[1]) return 4'b0010;
        if (sel[0]) return 4'b0001;
        return 4'b0000;
    endfunction

    function automatic logic [63:0] ref_result(input logic [3:0] sel, input logic [31:0] a, b, c);
        logic [3:0]  p = pick(sel);
        logic        borrow;
        logic [31:0] d;
        case (p)
            4'b1000: return ({32'b0, a} * {32'b0, b}) + {32'b0, c};
            4'b0100: return {b, a} + {32'b0, c};
            4'b0010: begin
                borrow = {1'b0, a} < ({1'b0, b} + {32'b0, c[0]});
                d      = a - b - {31'b0, c[0]};
                return {31'b0, borrow, d};
            end
            4'b0001: return {32'b0, a} + {32'b0, b} + {63'b0, c[0]};
            default: return '0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] sel);
        logic [3:0] p = pick(sel);
        if (p == 4'b1000) return 33;
        if (p == 4'b0100) return 1;
        if (p != 4'b0000) return 0;
        return -1;
    endfunction

    function automatic logic [63:0] ref_busy(input int lat);
        logic [63:0] m = '0;
        for (int k = 1; k <= lat; k++) m[k] = 1'b1;
        return m;
    endfunction

    task automatic model_update(input logic [3:0] sel, input logic [31:0] a, c, input logic [63:0] res);
        logic [3:0]  p = pick(sel);
        logic [32:0] lo;
        if (p == 4'b1000) begin
            m_acc   = res;
            m_carry = res[63];
            m_count = '0;
        end else if (p == 4'b0100) begin
            lo          = {1'b0, a} + {1'b0, c};
            m_acc[31:0] = lo[31:0];
            m_carry     = lo[32];
        end
    endtask

    // Drives one operation from posedge+1 of cycle 0; records ready cycle,
    // result, busy per cycle and whether result was nonzero while ready=0.
    task automatic do_op(input logic [3:0] sel, input logic [31:0] a, b, c, input int limit,
                         output int lat, output logic [63:0] res, output logic [63:0] bm,
                         output logic zbad);
        lat  = -1;
        res  = '0;
        bm   = '0;
        zbad = 1'b0;
        rs1 = a; rs2 = b; rs3 = c;
        {uop_mmul, uop_macc, uop_msub, uop_madd} = sel;
        valid = 1'b1;
        for (int cyc = 0; cyc < limit; cyc++) begin
            #4;
            bm[cyc] = busy;
            if (ready) begin
                lat = cyc;
                res = result;
            end else if (result !== 64'h0) begin
                zbad = 1'b1;
            end
            @(posedge g_clk); #1;
            if (lat >= 0) break;
        end
        valid = 1'b0;
        {uop_mmul, uop_macc, uop_msub, uop_madd} = 4'b0000;
    endtask

    task automatic test_reset();
        g_reset = 1'b1; flush = 1'b0; valid = 1'b0;
        rs1 = '0; rs2 = '0; rs3 = '0;
        {uop_mmul, uop_macc, uop_msub, uop_madd} = 4'b0000;
        m_acc = '0; m_carry = 1'b0; m_count = '0;
        repeat (2) @(posedge g_clk);
        #4;
        checks++; if (ready !== 1'b0)   $display("FAIL reset_ready: got %b expected 0", ready);
        if (ready !== 1'b0) errors++;
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (result !== 64'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
        checks++; if ({acc, carry, count} !== 71'h0) begin
            errors++; $display("FAIL reset_state: acc %h carry %b count %0d expected all 0", acc, carry, count);
        end
        @(posedge g_clk); #1;
        g_reset = 1'b0;
    endtask

    task automatic test_directed();
        int lat; logic [63:0] res, bm; logic zb;
        do_op(4'b0001, 32'hFFFFFFFF, 32'h1, 32'h1, 5, lat, res, bm, zb);
        checks++; if (lat !== 0) begin errors++; $display("FAIL madd_lat: got %0d expected 0", lat); end
        checks++; if (res !== 64'h00000001_00000001) begin errors++; $display("FAIL madd_res: got %h expected 0000000100000001", res); end
        #4;
        checks++; if (acc !== m_acc || count !== m_count) begin
            errors++; $display("FAIL madd_hold: acc %h count %0d expected %h %0d", acc, count, m_acc, m_count);
        end
        @(posedge g_clk); #1;
        do_op(4'b0010, 32'h0, 32'h1, 32'h0, 5, lat, res, bm, zb);
        checks++; if (lat !== 0) begin errors++; $display("FAIL msub_lat: got %0d expected 0", lat); end
        checks++; if (res !== 64'h00000001_FFFFFFFF) begin errors++; $display("FAIL msub_res: got %h expected 00000001ffffffff", res); end
        do_op(4'b0100, 32'hFFFFFFFF, 32'h1, 32'h1, 5, lat, res, bm, zb);
        checks++; if (lat !== 1) begin errors++; $display("FAIL macc_lat: got %0d expected 1", lat); end
        checks++; if (bm[1:0] !== 2'b10) begin errors++; $display("FAIL macc_busy: got %b expected 10", bm[1:0]); end
        checks++; if (res !== 64'h00000002_00000000) begin errors++; $display("FAIL macc_res: got %h expected 0000000200000000", res); end
        model_update(4'b0100, 32'hFFFFFFFF, 32'h1, res);
        #4;
        checks++; if (acc !== m_acc || carry !== m_carry) begin
            errors++; $display("FAIL macc_state: acc %h carry %b expected %h %b", acc, carry, m_acc, m_carry);
        end
        @(posedge g_clk); #1;
    endtask

    task automatic test_mmul_back_to_back();
        int lat; logic [63:0] res, bm; logic zb;
        lat = -1; res = '0;
        rs1 = 32'hFFFFFFFF; rs2 = 32'hFFFFFFFF; rs3 = 32'hFFFFFFFF;
        {uop_mmul, uop_macc, uop_msub, uop_madd} = 4'b1000;
        valid = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            #4;
            if (cyc >= 1 && cyc <= 32) begin
                checks++;
                if (count !== 6'(cyc - 1)) begin
                    errors++; $display("FAIL mmul_count c%0d: got %0d expected %0d", cyc, count, cyc - 1);
                end
            end
            checks++;
            if (busy !== (cyc >= 1)) begin errors++; $display("FAIL mmul_busy c%0d: got %b", cyc, busy); end
            if (ready) begin lat = cyc; res = result; end
            @(posedge g_clk); #1;
            if (lat >= 0) break;
        end
        checks++; if (lat !== 33) begin errors++; $display("FAIL mmul_lat: got %0d expected 33", lat); end
        checks++; if (res !== 64'hFFFFFFFF_00000000) begin errors++; $display("FAIL mmul_res: got %h expected ffffffff00000000", res); end
        model_update(4'b1000, rs1, rs3, 64'hFFFFFFFF_00000000);
        do_op(4'b0001, 32'h10, 32'h20, 32'h1, 5, lat, res, bm, zb);
        checks++; if (lat !== 0) begin errors++; $display("FAIL b2b_madd_lat: got %0d expected 0", lat); end
        checks++; if (res !== 64'h31) begin errors++; $display("FAIL b2b_madd_res: got %h expected 31", res); end
        #4;
        checks++; if (acc !== m_acc || carry !== m_carry || count !== m_count) begin
            errors++; $display("FAIL mmul_state: acc %h carry %b count %0d expected %h %b %0d",
                               acc, carry, count, m_acc, m_carry, m_count);
        end
        @(posedge g_clk); #1;
    endtask

    task automatic test_flush();
        int lat; logic [63:0] res, bm; logic zb; logic seen; logic [95:0] v;
        seen = 1'b0;
        rs1 = 32'd3; rs2 = 32'd5; rs3 = 32'd7;
        {uop_mmul, uop_macc, uop_msub, uop_madd} = 4'b1000;
        valid = 1'b1;
        for (int cyc = 0; cyc <= 10; cyc++) begin
            if (cyc == 10) flush = 1'b1;
            #4;
            if (ready) seen = 1'b1;
            @(posedge g_clk); #1;
        end
        flush = 1'b0; valid = 1'b0;
        {uop_mmul, uop_macc, uop_msub, uop_madd} = 4'b0000;
        // nine MUL steps completed before the flush edge
        v = {32'b0, 32'd7, 32'd5} + (({64'b0, 32'd3} * {64'b0, 32'd5 & 32'h1FF}) << 32);
        v = v >> 9;
        m_acc = v[63:0]; m_carry = 1'b0; m_count = '0;
        #4;
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b expected 0", seen); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", busy); end
        checks++; if (count !== 6'd0 || carry !== 1'b0) begin
            errors++; $display("FAIL flush_count: count %0d carry %b expected 0 0", count, carry);
        end
        checks++; if (acc !== m_acc) begin errors++; $display("FAIL flush_acc: got %h expected %h", acc, m_acc); end
        @(posedge g_clk); #1;
        rs1 = 32'd2; rs2 = 32'd3; rs3 = 32'd0;
        {uop_mmul, uop_macc, uop_msub, uop_madd} = 4'b0001;
        valid = 1'b1; flush = 1'b1;
        #4;
        checks++; if (ready !== 1'b0 || result !== 64'h0) begin
            errors++; $display("FAIL flush_idle_madd: ready %b result %h expected 0 0", ready, result);
        end
        @(posedge g_clk); #1;
        flush = 1'b0;
        do_op(4'b0001, 32'd2, 32'd3, 32'd0, 5, lat, res, bm, zb);
        checks++; if (lat !== 0 || res !== 64'd5) begin
            errors++; $display("FAIL post_flush_madd: lat %0d res %h expected 0 5", lat, res);
        end
    endtask

    task automatic test_no_select();
        int lat; logic [63:0] res, bm; logic zb;
        do_op(4'b0000, $urandom, $urandom, $urandom, 3, lat, res, bm, zb);
        checks++; if (lat !== -1 || bm !== 64'h0 || zb !== 1'b0) begin
            errors++; $display("FAIL no_select: lat %0d busy %h zbad %b expected -1 0 0", lat, bm, zb);
        end
    endtask

    task automatic test_random();
        int lat, el; logic [63:0] res, bm, er; logic zb;
        logic [3:0] sel; logic [31:0] a, b, c;
        for (int i = 0; i < 24; i++) begin
            sel = 4'($urandom_range(1, 15));
            a = $urandom; b = $urandom; c = $urandom;
            if (i % 6 == 0) a = 32'hFFFFFFFF;
            if (i % 7 == 0) b = a;
            do_op(sel, a, b, c, 40, lat, res, bm, zb);
            er = ref_result(sel, a, b, c);
            el = ref_lat(sel);
            checks++; if (lat !== el) begin errors++; $display("FAIL rnd%0d_lat sel=%b: got %0d expected %0d", i, sel, lat, el); end
            checks++; if (res !== er) begin errors++; $display("FAIL rnd%0d_res sel=%b: got %h expected %h", i, sel, res, er); end
            checks++; if (bm !== ref_busy(el)) begin errors++; $display("FAIL rnd%0d_busy: got %h expected %h", i, bm, ref_busy(el)); end
            checks++; if (zb !== 1'b0) begin errors++; $display("FAIL rnd%0d_zero: got nonzero result with ready low", i); end
            model_update(sel, a, c, er);
            #4;
            checks++; if (ready !== 1'b0 || acc !== m_acc || carry !== m_carry || count !== m_count) begin
                errors++; $display("FAIL rnd%0d_state: ready %b acc %h carry %b count %0d expected 0 %h %b %0d",
                                   i, ready, acc, carry, count, m_acc, m_carry, m_count);
            end
            @(posedge g_clk); #1;
        end
    endtask

    task automatic test_async_reset();
        int lat; logic [63:0] res, bm; logic zb;
        rs1 = $urandom; rs2 = $urandom; rs3 = $urandom;
        {uop_mmul, uop_macc, uop_msub, uop_madd} = 4'b1000;
        valid = 1'b1;
        repeat (5) begin @(posedge g_clk); #1; end
        g_reset = 1'b1;
        #2;
        checks++; if ({ready, busy, result, acc, carry, count} !== 136'h0) begin
            errors++; $display("FAIL async_reset: ready %b busy %b result %h acc %h carry %b count %0d expected all 0",
                               ready, busy, result, acc, carry, count);
        end
        @(posedge g_clk); #3;
        checks++; if (busy !== 1'b0 || ready !== 1'b0 || acc !== 64'h0) begin
            errors++; $display("FAIL reset_held: busy %b ready %b acc %h expected 0 0 0", busy, ready, acc);
        end
        g_reset = 1'b0; valid = 1'b0;
        {uop_mmul, uop_macc, uop_msub, uop_madd} = 4'b0000;
        m_acc = '0; m_carry = 1'b0; m_count = '0;
        @(posedge g_clk); #1;
        do_op(4'b1000, 32'd2, 32'd3, 32'd0, 40, lat, res, bm, zb);
        checks++; if (lat !== 33) begin errors++; $display("FAIL post_reset_mmul_lat: got %0d expected 33", lat); end
        checks++; if (res !== 64'd6) begin errors++; $display("FAIL post_reset_mmul_res: got %h expected 6", res); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mmul_back_to_back();
        test_flush();
        test_no_select();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
